// File: rtl/mem_access_unit.sv
// Load/store front end: accepts word requests, drives a read-first block RAM directly and
// returns one in-order response per request through a small credit-protected response FIFO.
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 400001,
    parameter int RSP_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1) + 1;

    // Handshake: a request transfers on a rising edge where req_valid & req_ready,
    // a response transfers where rsp_valid & rsp_ready; neither side may retract early.
    logic              acc;
    logic              inr;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   push_entry;
    logic [DATA_W:0]   head;

    logic [DATA_W:0]   fifo_q [RSP_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic              inflight_err_q, inflight_err_d;

    // Credit counts the response still coming out of the RAM, so the push never overflows.
    assign req_ready = ~rst & ((occ_q + CW'(inflight_q)) < CW'(RSP_DEPTH));
    assign acc       = req_valid & req_ready;
    assign inr       = req_addr < ADDR_W'(MEM_DEPTH);

    assign ram_en   = acc & inr;
    assign ram_we   = acc & inr & req_we;
    assign ram_addr = req_addr;
    assign ram_di   = req_wdata;

    assign push       = inflight_q;
    assign push_entry = inflight_err_q ? {{DATA_W{1'b0}}, 1'b1} : {ram_dout, 1'b0};
    assign head       = fifo_q[rd_ptr_q];

    assign rsp_valid = ~rst & (occ_q != '0);
    assign rsp_rdata = rsp_valid ? head[DATA_W:1] : '0;
    assign rsp_err   = rsp_valid & head[0];
    assign pop       = rsp_valid & rsp_ready;

    always_comb begin
        inflight_d     = acc;
        inflight_err_d = acc & ~inr;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occ_d          = occ_q;
        // Explicit wrap keeps non-power-of-two depths correct.
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + CW'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            inflight_q     <= inflight_d;
            inflight_err_q <= inflight_err_d;
        end
    end

    // Storage needs no reset: an entry is only visible after it has been written.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: read-first RAM model, expected-response queue
// checked by a response monitor, and cycle-exact checks of handshake timing.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [31:0] mem [int unsigned];

    mem_access_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_di    (ram_di),
        .ram_dout  (ram_dout)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // read-first RAM with 1-cycle registered read
    initial ram_dout = 32'h0;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= mem_rd(ram_addr);
            if (ram_we) mem[ram_addr] = ram_di;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // scoreboard: every consumed response must match the head of exp_q
    always @(negedge clk) begin
        #2;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e[31:0]);
                chk("rsp_err", rsp_err, mon_e[32]);
            end
        end
    end

    initial begin
        int nxt;
        int acc_n;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd4;
        req_wdata = 32'h0; rsp_ready = 1'b0;

        // 1: reset holds everything quiet
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_ram_en", ram_en, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", {rsp_err, rsp_rdata}, 0);
            tick();
        end
        rst = 1'b0; req_valid = 1'b0;
        #1 chk("rst_release_ready", req_ready, 1);
        tick();

        // 2: store then load of the same word
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'hDEADBEEF;
        #1 chk("st_ram_en", {ram_en, ram_we}, 2'b11);
        exp_q.push_back({1'b0, 32'h0});
        tick();
        req_we = 1'b0;
        #1 chk("ld_ram_en", {ram_en, ram_we}, 2'b10);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        tick();
        req_valid = 1'b0;
        #1 chk("sl_valid_t2", rsp_valid, 1);
        tick();
        #1 chk("sl_valid_t3", rsp_valid, 1);
        tick();
        #1 chk("sl_valid_t4", rsp_valid, 0);
        tick();

        // 3: back-to-back loads
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        mem[400000] = 32'hCAFE0001;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = i;
            #1 chk("stream_ready", req_ready, 1);
            exp_q.push_back({1'b0, 32'h100 + i});
            if (i >= 2) chk("stream_valid", rsp_valid, 1);
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("stream_tail_valid", rsp_valid, 1);
            tick();
        end
        #1 chk("stream_end_valid", rsp_valid, 0);
        drain();

        // 4: backpressure
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
        nxt = 10; acc_n = 0;
        for (int c = 0; c < 6; c++) begin
            req_addr = nxt;
            #1;
            if (req_ready) begin
                exp_q.push_back({1'b0, 32'h100 + nxt});
                nxt++;
                acc_n++;
            end
            if (c >= 2) chk("bp_hold", {rsp_valid, rsp_rdata}, {1'b1, 32'h10A});
            tick();
        end
        chk("bp_acc_cnt", acc_n, 3);
        req_addr = nxt;
        rsp_ready = 1'b1;
        #1 chk("bp_stall", req_ready, 0);
        tick();
        #1 chk("bp_resume", req_ready, 1);
        chk("bp_resume_addr", req_addr, 13);
        exp_q.push_back({1'b0, 32'h10D});
        tick();
        req_valid = 1'b0;
        drain();

        // 5: out-of-range addresses
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd400001;
        #1 chk("oor_ld", {req_ready, ram_en}, 2'b10);
        exp_q.push_back({1'b1, 32'h0});
        tick();
        req_we = 1'b1; req_addr = 32'hFFFFFFFF; req_wdata = 32'hFFFFFFFF;
        #1 chk("oor_st", {req_ready, ram_en, ram_we}, 3'b100);
        exp_q.push_back({1'b1, 32'h0});
        tick();
        req_we = 1'b0; req_addr = 32'd400000;
        #1 chk("last_ld", {req_ready, ram_en}, 2'b11);
        exp_q.push_back({1'b0, 32'hCAFE0001});
        tick();
        req_valid = 1'b0;
        drain();

        // 6: reset while loads are in flight
        req_valid = 1'b1; req_addr = 32'd1;
        #1 chk("mid_acc1", req_ready, 1);
        tick();
        req_addr = 32'd2;
        #1 chk("mid_acc2", req_ready, 1);
        tick();
        rst = 1'b1; req_valid = 1'b0;
        #1 chk("mid_rst_out", {rsp_valid, req_ready}, 2'b00);
        tick();
        rst = 1'b0;
        #1 chk("mid_release_ready", req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("mid_no_stale", rsp_valid, 0);
            tick();
        end

        chk("final_q", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end between the CPU memory stage and the single-port read-first data block RAM (32-bit word-addressed, 1-cycle registered read, `en`/`we`/`addr`/`di`/`dout`). It accepts word requests over a valid/ready handshake and bounds-checks the address. It drives the RAM port directly and captures `dout` one cycle later. Every request produces exactly one in-order response through a small response FIFO, so the CPU can backpressure without losing RAM read data.

Parameters:
ADDR_W, 32, request/RAM address width (word address)
DATA_W, 32, data width
MEM_DEPTH, 400001, number of valid RAM words; valid addresses are 0..MEM_DEPTH-1
RSP_DEPTH, 3, response FIFO entries; must be >=2; >=3 needed for 1 req/cycle throughput

Ports:
clk        in   1       clock, all state on rising edge
rst        in   1       synchronous reset, active-high
req_valid  in   1       request valid
req_ready  out  1       request accepted when req_valid & req_ready
req_we     in   1       1 = store, 0 = load
req_addr   in   ADDR_W  word address
req_wdata  in   DATA_W  store data
rsp_valid  out  1       response valid
rsp_ready  in   1       response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  load data; for stores, the word's prior content (read-first)
rsp_err    out  1       1 = address out of range
ram_en     out  1       to RAM en
ram_we     out  1       to RAM we
ram_addr   out  ADDR_W  to RAM addr
ram_di     out  DATA_W  to RAM di
ram_dout   in   DATA_W  from RAM dout, valid the cycle after ram_en

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- `acc` = req_valid & req_ready; `inr` = (req_addr < MEM_DEPTH).
- RAM drive is combinational in the accept cycle:
  - ram_en = acc & inr
  - ram_we = acc & inr & req_we
  - ram_addr = req_addr
  - ram_di = req_wdata
- Out-of-range requests never touch the RAM, so no write occurs.
- Capture stage: registered `inflight`, `inflight_err` set on acc. In the next cycle, push {ram_dout, 0} into the FIFO, or {0, 1} if inflight_err. The push is unconditional; credit guarantees space.
- Credit: req_ready = ~rst & ((occ + inflight) < RSP_DEPTH). There is no combinational path from rsp_ready to req_ready.
- Response: rsp_valid = (occ != 0), with head on rsp_rdata/rsp_err. A pop occurs on rsp_valid & rsp_ready.
- Push and pop in the same cycle: occ is unchanged. Push into an empty FIFO: visible next cycle (no bypass).
- Latency: accept in cycle T gives rsp_valid in cycle T+2.
- Throughput: with RSP_DEPTH >= 3 and rsp_ready held 1, one request accepted and one response returned every cycle.
- Ordering: responses leave strictly in acceptance order; loads and stores are never reordered.
- Backpressure: while rsp_valid & ~rsp_ready, head data is stable. Acceptance stops once occ + inflight = RSP_DEPTH.
- Reset values (any cycle with rst=1):
  - inflight = 0, occ = 0, FIFO pointers = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - req_ready = 0, ram_en = 0, ram_we = 0
- Reset mid-operation: in-flight and queued responses are discarded; no stale response appears after rst falls. RAM writes already performed remain.
- Pointers wrap modulo RSP_DEPTH; the implementation must not assume a power-of-2 depth.
- Width rules: the address compare is unsigned at ADDR_W bits. No byte enables; full-word accesses only.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with req_valid=1, addr=4 -> ram_en=0, req_ready=0, rsp_valid=0 throughout; req_ready=1 in the first cycle after rst=0.
2. Store then load: store 0xDEADBEEF to addr 5 at T, load addr 5 at T+1, rsp_ready=1, RAM pre-zeroed ->
   - rsp at T+2: rdata=0x00000000, err=0
   - rsp at T+3: rdata=0xDEADBEEF, err=0
3. Streaming: loads addr 0..7 on consecutive cycles, mem[i]=i+0x100, rsp_ready=1 -> req_ready stays 1; 8 responses 0x100..0x107 in order on 8 consecutive cycles starting 2 cycles after the first accept.
4. Backpressure: rsp_ready=0, continuous loads addr 10,11,12,13,... ->
   - exactly 3 accepted, then req_ready=0
   - rsp_rdata holds mem[10] stable
   - raising rsp_ready drains 10, 11, 12 in order, then acceptance resumes at 13
5. Out of range: load addr 400001, then store 0xFFFFFFFF to addr 0xFFFFFFFF -> ram_en=0 on both accepts; both responses err=1, rdata=0; a subsequent load of addr 400000 returns err=0.
6. Reset mid-operation: accept loads at addr 1,2; assert rst for 1 cycle in the next cycle -> no rsp_valid ever seen for either; occ=0; req_ready=1 the cycle after rst falls.
